// File: rtl/rc4_pkg.sv
// rtl/rc4_pkg.sv - shared state encoding and defaults for the RC4 stream sequencer
package rc4_pkg;
  localparam int KEY_W       = 32;
  localparam int TIMEOUT_DEF = 1024;
  localparam int DROP_N_DEF  = 0;
  // Wide enough to count up to 4095 dropped bytes without wrapping.
  localparam int DROP_CW     = 13;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_INIT,
    ST_DROP_REQ,
    ST_DROP_WAIT,
    ST_DATA_WAIT,
    ST_KS_REQ,
    ST_KS_WAIT,
    ST_OUT,
    ST_ERROR
  } state_t;
endpackage

// File: rtl/rc4_wait_timer.sv
// rtl/rc4_wait_timer.sv - loadable down-counter flagging expiry of a core wait
module rc4_wait_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expired = (cnt == '0);
endmodule

// File: rtl/rc4_stream_ctrl.sv
// rtl/rc4_stream_ctrl.sv - RC4 sequencer: key schedule, drop[n], one keystream byte XORed per data byte
module rc4_stream_ctrl
  import rc4_pkg::*;
#(
  parameter int DROP_N  = DROP_N_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int LEN_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [KEY_W-1:0] cfg_key,
  input  logic [7:0]       cfg_key_len,
  input  logic [LEN_W-1:0] cfg_msg_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             core_start,
  output logic [KEY_W-1:0] core_key,
  output logic [7:0]       core_key_len,
  input  logic             core_init_done,
  output logic             core_ks_req,
  input  logic             core_ks_valid,
  input  logic [7:0]       core_ks_byte,
  output logic             busy,
  output logic             err
);
  localparam int TW = $clog2(TIMEOUT);

  state_t             state, state_next, after_init;
  logic [KEY_W-1:0]   key_q;
  logic [7:0]         key_len_q;
  logic [LEN_W-1:0]   msg_len_q, byte_cnt;
  logic [DROP_CW-1:0] drop_cnt;
  logic [7:0]         data_q, out_q;
  logic               last_q, err_q;
  logic               tmr_load, tmr_expired, drop_done, cfg_take, timeout_hit;

  // Loaded with TIMEOUT-2 so the error state is entered TIMEOUT cycles after the request cycle.
  rc4_wait_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (TW'(TIMEOUT - 2)),
    .expired  (tmr_expired)
  );

  assign after_init  = (msg_len_q == '0) ? ST_IDLE : ST_DATA_WAIT;
  assign drop_done   = (drop_cnt == DROP_CW'(DROP_N - 1));
  assign cfg_take    = cfg_ready && cfg_valid;
  assign timeout_hit = (state_next == ST_ERROR) && (state != ST_ERROR);
  assign out_data    = out_q;
  assign core_key    = key_q;
  assign core_key_len = key_len_q;
  assign err         = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    cfg_ready   = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    core_start  = 1'b0;
    core_ks_req = 1'b0;
    tmr_load    = 1'b0;
    busy        = 1'b1;
    case (state)
      ST_IDLE, ST_ERROR: begin
        cfg_ready = 1'b1;
        busy      = 1'b0;
        if (cfg_valid) state_next = ST_START;
      end
      ST_START: begin
        core_start = 1'b1;
        tmr_load   = 1'b1;
        state_next = ST_WAIT_INIT;
      end
      ST_WAIT_INIT: begin
        if (core_init_done) state_next = (DROP_N > 0) ? ST_DROP_REQ : after_init;
        else if (tmr_expired) state_next = ST_ERROR;
      end
      ST_DROP_REQ: begin
        core_ks_req = 1'b1;
        tmr_load    = 1'b1;
        state_next  = ST_DROP_WAIT;
      end
      ST_DROP_WAIT: begin
        if (core_ks_valid) state_next = drop_done ? after_init : ST_DROP_REQ;
        else if (tmr_expired) state_next = ST_ERROR;
      end
      ST_DATA_WAIT: begin
        in_ready = 1'b1;
        if (in_valid) state_next = ST_KS_REQ;
      end
      ST_KS_REQ: begin
        core_ks_req = 1'b1;
        tmr_load    = 1'b1;
        state_next  = ST_KS_WAIT;
      end
      ST_KS_WAIT: begin
        if (core_ks_valid) state_next = ST_OUT;
        else if (tmr_expired) state_next = ST_ERROR;
      end
      ST_OUT: begin
        out_valid = 1'b1;
        out_last  = last_q;
        if (out_ready) state_next = last_q ? ST_IDLE : ST_DATA_WAIT;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_q     <= '0;
      key_len_q <= '0;
      msg_len_q <= '0;
      byte_cnt  <= '0;
      drop_cnt  <= '0;
      data_q    <= '0;
      out_q     <= '0;
      last_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (cfg_take) begin
        key_q     <= cfg_key;
        key_len_q <= (cfg_key_len == 8'd0) ? 8'd1 : cfg_key_len;
        msg_len_q <= cfg_msg_len;
        byte_cnt  <= '0;
        drop_cnt  <= '0;
        err_q     <= 1'b0;
      end
      if (state == ST_DROP_WAIT && core_ks_valid) drop_cnt <= drop_cnt + DROP_CW'(1);
      if (state == ST_DATA_WAIT && in_valid) data_q <= in_data;
      if (state == ST_KS_WAIT && core_ks_valid) begin
        out_q  <= data_q ^ core_ks_byte;
        last_q <= (byte_cnt == msg_len_q - LEN_W'(1));
      end
      if (state == ST_OUT && out_ready) byte_cnt <= byte_cnt + LEN_W'(1);
      if (timeout_hit) err_q <= 1'b1;
    end
  end
endmodule

// File: doc/rc4_stream_ctrl.md
Name: rc4_stream_ctrl

Overview:
Sequencer in front of the RC4 keystream core. It latches a key/length configuration and runs the core's key-scheduling phase. It then discards DROP_N keystream bytes (RC4-drop[n]) and XORs one keystream byte onto each input data byte, using valid/ready handshakes on both sides. It also counts message bytes, flags the last byte, and times out a hung core.

Parameters:
DROP_N, 0, keystream bytes discarded after init before the first data byte (0..4095)
TIMEOUT, 1024, max cycles waiting on any core response before error (>=4)
LEN_W, 16, width of message byte counter

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cfg_valid  in  1  new key/message config offered
cfg_ready  out  1  controller can accept config (IDLE/ERROR only)
cfg_key  in  32  key word
cfg_key_len  in  8  key length in bytes; 0 treated as 1
cfg_msg_len  in  LEN_W  message length in bytes; 0 = no data phase
in_valid  in  1  plaintext/ciphertext byte valid
in_ready  out  1  controller accepts input byte
in_data  in  8  input byte
out_valid  out  1  result byte valid
out_ready  in  1  downstream accepts result
out_data  out  8  in_data XOR keystream
out_last  out  1  qualifies final byte of message
core_start  out  1  one-cycle pulse starting core key schedule
core_key  out  32  registered key to core
core_key_len  out  8  registered key length to core
core_init_done  in  1  core level: key schedule complete
core_ks_req  out  1  one-cycle pulse requesting next keystream byte
core_ks_valid  in  1  one-cycle pulse: core_ks_byte valid
core_ks_byte  in  8  keystream byte
busy  out  1  state != IDLE and != ERROR
err  out  1  sticky timeout flag, cleared by next accepted cfg

Behaviour:
- Reset values: all outputs 0 except cfg_ready=1. State=IDLE, counters=0.
- States: IDLE, START, WAIT_INIT, DROP_REQ, DROP_WAIT, DATA_WAIT, KS_REQ, KS_WAIT, OUT, ERROR.
- IDLE/ERROR: cfg_ready=1. On cfg_valid, latch key, key_len (0->1) and msg_len; clear err; go to START.
- START: core_start=1 for exactly one cycle -> WAIT_INIT.
- WAIT_INIT: on core_init_done=1, go to DROP_REQ if DROP_N>0. Otherwise go to DATA_WAIT, or to IDLE if msg_len==0.
- DROP_REQ: pulse core_ks_req -> DROP_WAIT. On core_ks_valid, discard the byte and increment drop_cnt. Return to DROP_REQ until drop_cnt==DROP_N, then go to DATA_WAIT (or IDLE if msg_len==0).
- DATA_WAIT: in_ready=1. On in_valid, latch in_data -> KS_REQ. Input bytes are never accepted while out_valid=1.
- KS_REQ: pulse core_ks_req once -> KS_WAIT.
- KS_WAIT: on core_ks_valid, out_data <= latched byte XOR core_ks_byte and out_valid <= 1. out_last <= (byte_cnt == msg_len-1). Go to OUT.
- OUT: hold out_data, out_valid and out_last stable until out_ready. On the transfer, byte_cnt++. Go to IDLE if last, else DATA_WAIT.
- Throughput: at most 1 byte per 4 cycles plus core latency. There is no keystream prefetch; a keystream byte is never requested before its data byte is held.
- Timeout: a wait counter resets on entry to WAIT_INIT, DROP_WAIT and KS_WAIT. Reaching TIMEOUT-1 -> err=1, state ERROR. Pending data is dropped and out_valid=0. Nothing times out on the out_ready stall.
- Stray core_ks_valid outside DROP_WAIT/KS_WAIT is ignored. cfg_valid outside IDLE/ERROR is ignored (cfg_ready=0).
- Synchronous reset mid-operation returns everything to reset values on the next edge; a partially received keystream byte is discarded. The core must be reset by the same rst_n.
- byte_cnt is LEN_W bits, compared with msg_len-1 in LEN_W arithmetic. A message of 2^LEN_W-1 bytes ends correctly.
- core_start and core_ks_req are never asserted in the same cycle.

Decomposition:
- Shared package rc4_pkg: state enum, TIMEOUT/DROP_N defaults, KEY_W=32.
- One sub-module, rc4_wait_timer: loadable down-counter with expire flag, reused for all three wait states.
- Everything else stays inline.

Test Plan:
- Config key=0x01020304, len=4, msg_len=3, DROP_N=0, ideal core model. Send 0x00,0xFF,0x55 -> out equals keystream, ~keystream, keystream^0x55; out_last only on the 3rd byte; busy drops after it.
- DROP_N=4 -> exactly 4 core_ks_req pulses before in_ready first rises; the first out byte uses the 5th keystream byte.
- Hold out_ready=0 for 20 cycles mid-message -> out_data/out_valid stable, in_ready=0, no extra core_ks_req; message completes after release.
- Core never asserts core_init_done -> err=1 and ERROR at TIMEOUT cycles after START. Then a new cfg is accepted, err clears and the run completes.
- msg_len=0 -> one core_start and no core_ks_req; returns to IDLE after init. cfg_key_len=0 drives core_key_len=1.
- rst_n low for 1 cycle while in KS_WAIT -> all outputs at reset values next cycle, cfg_ready=1, and a late core_ks_valid is ignored.
